yutorina_bus_if: RTL

- Memory-access controller between one pipeline stage (IF or MEM) of yutorina_cpu and two memory resources: the on-chip scratchpad memory port (yutorina_spm i- or d-port) and the shared external bus.
- Decodes each access by address. SPM hits complete in zero wait cycles.
- Other accesses run through a request/grant/strobe/ready FSM on the external bus; the pipeline is stalled via busy until the access completes.
- Two instances per CPU: one for IF, one for MEM.

---
 rtl/yutorina_bus_if_pkg.sv | 25 ++
 rtl/yutorina_bus_if.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_if_pkg.sv
// yutorina_bus_if shared constants: FSM state codes, access direction,
// SPM region defaults and timeout counter sizing.
`timescale 1ns/1ps
package yutorina_bus_if_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int SPM_ADDR_W_DEF  = 12;
  localparam int SPM_BASE_HI_DEF = 0;

  localparam int TIMEOUT_W = 8;

  // Counter is at least 8 bits, wider only if the limit needs it.
  function automatic int cnt_width(input int tmo);
    if (tmo > 255) return $clog2(tmo + 1);
    return TIMEOUT_W;
  endfunction

endpackage

// File: rtl/yutorina_bus_if.sv
// yutorina_bus_if: IF/MEM access controller. SPM hits complete in zero
// wait cycles; other addresses run a req/grant/strobe/ready bus cycle.
// Ports: clk, rst (async, active high), pipeline side (stall, flush,
// addr, as_, rw, wr_data, rd_data, busy), SPM side (spm_*), external
// bus side (bus_*). Define BUS_TIMEOUT_EN to add the TIMEOUT parameter,
// the ACCESS wait counter and the err pulse output.
`timescale 1ns/1ps
module yutorina_bus_if
  import yutorina_bus_if_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int SPM_ADDR_W  = SPM_ADDR_W_DEF,
  parameter int SPM_BASE_HI = SPM_BASE_HI_DEF
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_
`ifdef BUS_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  localparam int HI_W = ADDR_W - SPM_ADDR_W;
  localparam logic [HI_W-1:0] BASE_HI =
    HI_W'(SPM_BASE_HI);

  logic [1:0]        r_state;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic              r_bus_rw;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wr_data;
  logic [DATA_W-1:0] r_rd_buf;

  logic w_hit;
  logic w_idle;
  logic w_acc;
  logic w_stall;
  logic w_spm_sel;
  logic w_bus_start;
  logic w_rdy;
  logic w_tmo;

  assign w_hit   = addr[ADDR_W-1:SPM_ADDR_W] == BASE_HI;
  assign w_idle  = r_state == ST_IDLE;
  assign w_acc   = r_state == ST_ACCESS;
  assign w_stall = r_state == ST_STALL;

  assign w_spm_sel   = w_idle & ~as_ & w_hit & ~flush;
  assign w_bus_start = w_idle & ~as_ & ~w_hit & ~flush;
  assign w_rdy       = w_acc & ~bus_rdy_;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Abort in the ACCESS cycle that brings the wait count to TIMEOUT.
  assign w_tmo = w_acc & bus_rdy_ &
                 (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (r_state == ST_REQ && !flush && !bus_grnt_)
        r_cnt <= '0;
      else if (w_acc && bus_rdy_)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign err = r_err;
`else
  assign w_tmo = 1'b0;
`endif

  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_as_     = ~w_spm_sel;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;

  // Busy rises in the launch cycle itself, drops in the ready cycle.
  assign busy = w_bus_start |
                (r_state == ST_REQ) |
                (w_acc & bus_rdy_ & ~w_tmo);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      w_spm_sel: rd_data = spm_rd_data;
      w_rdy:     rd_data = bus_rd_data;
      w_stall:   rd_data = r_rd_buf;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bus_req_    <= 1'b1;
      r_bus_as_     <= 1'b1;
      r_bus_rw      <= READ;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_rd_buf      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_bus_start) begin
            r_bus_addr    <= addr;
            r_bus_rw      <= rw;
            r_bus_wr_data <= wr_data;
            r_bus_req_    <= 1'b0;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // No grant consumed yet, so a flush may still back out.
          if (flush) begin
            r_bus_req_ <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (!bus_grnt_) begin
            r_bus_as_ <= 1'b0;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            r_rd_buf   <= bus_rd_data;
            r_bus_req_ <= 1'b1;
            r_state    <= stall ? ST_STALL : ST_IDLE;
          end else if (w_tmo) begin
            r_bus_req_ <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!stall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
